tile_cmd_sequencer: RTL

//  Switch-side initiator for a compute_tile. Accepts host commands over valid/ready.

---
 rtl/tile_cmd_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/tile_cmd_sequencer.sv
// Host-command sequencer for a compute_tile: queues commands, drives switch frames, returns results.
// Optional frame counter enabled by defining TILE_CMD_SEQ_FRAME_COUNT_EN.
module tile_cmd_sequencer #(
  parameter int DEPTH      = 4,
  parameter int RESULT_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_type,
  input  logic [5:0]                cmd_payload,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [7:0]                res_data,
  output logic [7:0]                switch_data_out,
  input  logic [7:0]                switch_data_in,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [7:0]                frame_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            res_valid_reg, res_valid_next;
  logic [7:0]      res_data_reg, res_data_next;
  logic [7:0]      frame_reg, frame_next;
  logic [AW-1:0]   rd_ptr_reg, wr_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic [7:0]      mem [DEPTH];
  logic [7:0]      head;
  logic            push, pop;

  assign cmd_ready       = (level_reg != LW'(DEPTH));
  assign push            = cmd_valid && cmd_ready;
  assign head            = mem[rd_ptr_reg];
  assign res_valid       = res_valid_reg;
  assign res_data        = res_data_reg;
  assign switch_data_out = frame_reg;
  assign fifo_level      = level_reg;
  assign busy            = (state_reg != IDLE) || (level_reg != '0);

  // Storage carries no reset; entries are only read while the level says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {cmd_type, cmd_payload};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= 8'h00;
      frame_reg     <= 8'h00;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      res_valid_reg <= res_valid_next;
      res_data_reg  <= res_data_next;
      frame_reg     <= frame_next;
    end
  end

  // The frame register is never cleared between commands: the tile re-applies it every cycle.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    res_valid_next = res_valid_reg;
    res_data_next  = res_data_reg;
    frame_next     = frame_reg;
    pop            = 1'b0;
    case (state_reg)
      IDLE: begin
        if (level_reg != '0) begin
          pop        = 1'b1;
          frame_next = head;
          if (head[7]) begin
            state_next = WAIT;
            cnt_next   = CW'(RESULT_LAT - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          res_data_next  = switch_data_in;
          res_valid_next = 1'b1;
          state_next     = HOLD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      HOLD: begin
        if (res_valid_reg && res_ready) begin
          res_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef TILE_CMD_SEQ_FRAME_COUNT_EN
  logic [7:0] frame_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   frame_count_reg <= 8'h00;
    else if (pop) frame_count_reg <= frame_count_reg + 8'h01;
  end

  assign frame_count = frame_count_reg;
`else
  assign frame_count = 8'h00;
`endif

endmodule
